// File: rtl/qdma_master_pkg.sv
// Shared types and timing defaults for the QBUS DMA bus-master engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package qdma_master_pkg;

    // Default QBUS timing in qclk cycles at 20 MHz
    localparam int QSIC_ADDR_SETUP  = 3;    // 150 ns address setup before SYNC
    localparam int QSIC_DATA_SETUP  = 2;    // data setup before DOUT
    localparam int QSIC_NXM_TIMEOUT = 200;  // 10 us without RPLY means no memory there

    // Words moved per bus tenure when burst mode is built in
    localparam int QSIC_BURST_LIMIT = 8;

    // Upper address bits that select the I/O page (BS7 asserted)
    localparam logic [8:0] QSIC_BS7_PAGE = 9'h1FF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_ADDR,
        S_SYNC,
        S_DATA,
        S_TERM,
        S_NEXT,
        S_DONE
    } state_t;

    // Byte address of the following word; 22-bit wrap is natural
    function automatic logic [21:0] next_addr(input logic [21:0] a, input logic inh);
        return inh ? a : a + 22'd2;
    endfunction

endpackage

// File: rtl/qdma_master_if.sv
// QBUS arbitration and bus-cycle control lines of one DMA master.
// Latency: n/a (wires only).
// Backpressure: bus slaves stall via RRPLY; arbiter stalls via RDMGI.
interface qdma_master_if;
    logic TDMR;
    logic RDMGI;
    logic TDMGO;
    logic TSACK;
    logic RSYNC;
    logic RRPLY;
    logic TSYNC;
    logic TDIN;
    logic TDOUT;
    logic TWTBT;
    logic TBS7;
    logic DALbe_L;
    logic DALtx;
    logic DALst;

    // DMA engine side
    modport master (
        output TDMR, TDMGO, TSACK, TSYNC, TDIN, TDOUT, TWTBT, TBS7,
        output DALbe_L, DALtx, DALst,
        input  RDMGI, RSYNC, RRPLY
    );

    // Bus / arbiter / memory side
    modport slave (
        input  TDMR, TDMGO, TSACK, TSYNC, TDIN, TDOUT, TWTBT, TBS7,
        input  DALbe_L, DALtx, DALst,
        output RDMGI, RSYNC, RRPLY
    );
endinterface

// File: rtl/qdma_master_arb.sv
// QBUS DMR/DMG/SACK handshake with grant daisy-chain pass-through (module qdma_arb).
// Latency: TSACK asserts the cycle after a grant is seen while requesting.
// Backpressure: request held until RDMGI; grants pass downstream whenever the engine is idle.
module qdma_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,     // engine is in its request state
    input  logic rel_i,     // engine gives up the bus
    input  logic idle_i,    // engine idle: grant belongs to someone downstream
    input  logic rdmgi_i,
    output logic tdmr_o,
    output logic tdmgo_o,
    output logic tsack_o,
    output logic gnt_o      // grant absorbed this cycle
);

    logic tsack_q;

    assign tdmr_o  = req_i;
    assign gnt_o   = req_i & rdmgi_i;
    // Only an idle engine forwards the grant; a requesting one swallows it
    assign tdmgo_o = idle_i & rdmgi_i & ~rst_i;
    assign tsack_o = tsack_q;

    // SACK set on absorbed grant, held until the engine releases the tenure
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tsack_q <= 1'b0;
        end else if (gnt_o) begin
            tsack_q <= 1'b1;
        end else if (rel_i) begin
            tsack_q <= 1'b0;
        end
    end

endmodule

// File: rtl/qdma_master.sv
// QBUS DMA master: moves up to one 256-word sector between the sector buffer and memory (optional burst: QDMA_BURST_EN).
// Latency: per word ~ arbitration + ADDR_SETUP + 1 + memory reply + 2 cycles; done pulses 1 cycle after the last word.
// Backpressure: waits on RDMGI and RRPLY; aborts with nxm after NXM_TIMEOUT cycles without RRPLY.
module qdma_master
    import qdma_master_pkg::*;
#(
    parameter int ADDR_SETUP  = QSIC_ADDR_SETUP,
    parameter int DATA_SETUP  = QSIC_DATA_SETUP,
    parameter int NXM_TIMEOUT = QSIC_NXM_TIMEOUT
) (
    input  logic          qclk,
    input  logic          init,
    input  logic          start,
    input  logic          to_mem,
    input  logic [21:0]   addr_in,
    input  logic [15:0]   wc_in,
    input  logic          inh_ba,
    output logic          busy,
    output logic          done,
    output logic          nxm,
    output logic [21:0]   addr_out,
    output logic [15:0]   wc_out,
    output logic [7:0]    buf_addr,
    input  logic [15:0]   buf_rdata,
    output logic [15:0]   buf_wdata,
    output logic          buf_we,
    qdma_master_if.master qbus,
    inout  wire  [21:0]   ZDAL
);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [21:0] addr_q, addr_d;
    logic [15:0] wc_q, wc_d;
    logic [7:0]  badr_q, badr_d;
    logic        nxm_q, nxm_d;
    logic [15:0] wdat_q, wdat_d;
    logic        we_q, we_d;
    logic        dir_q, dir_d;
    logic        inh_q, inh_d;
`ifdef QDMA_BURST_EN
    logic [2:0]  burst_q, burst_d;
`endif

    logic        arb_req, arb_rel, arb_gnt;
    logic        strobe_on;
    logic        dal_oe;
    logic [21:0] dal_val;
    logic        tsync, tdin, tdout, twtbt, tbs7, dalbe_l, daltx, dalst;

    qdma_arb u_arb (
        .clk_i   (qclk),
        .rst_i   (init),
        .req_i   (arb_req),
        .rel_i   (arb_rel),
        .idle_i  (state_q == S_IDLE),
        .rdmgi_i (qbus.RDMGI),
        .tdmr_o  (qbus.TDMR),
        .tdmgo_o (qbus.TDMGO),
        .tsack_o (qbus.TSACK),
        .gnt_o   (arb_gnt)
    );

    assign arb_req = (state_q == S_REQ);

    // DOUT only after the data setup time; DIN immediately. RPLY counts only once strobed.
    assign strobe_on = dir_q ? (cnt_q >= 16'(DATA_SETUP - 1)) : 1'b1;

    // Word sequencing, bus-cycle progress and address/count bookkeeping
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        badr_d  = badr_q;
        nxm_d   = nxm_q;
        wdat_d  = wdat_q;
        we_d    = 1'b0;
        dir_d   = dir_q;
        inh_d   = inh_q;
        arb_rel = 1'b0;
        cnt_d   = cnt_q + 16'd1;
`ifdef QDMA_BURST_EN
        burst_d = burst_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = addr_in & ~22'd1;
                    wc_d    = wc_in;
                    dir_d   = to_mem;
                    inh_d   = inh_ba;
                    nxm_d   = 1'b0;
                    badr_d  = 8'd0;
                    state_d = (wc_in == 16'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (arb_gnt) begin
                    state_d = S_ACK;
`ifdef QDMA_BURST_EN
                    burst_d = 3'd0;
`endif
                end
            end
            S_ACK: begin
                // Previous master must have finished its cycle
                if (!qbus.RSYNC && !qbus.RRPLY) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_q == 16'(ADDR_SETUP - 1)) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (qbus.RRPLY && strobe_on) begin
                    wdat_d  = ZDAL[15:0];
                    we_d    = ~dir_q;
                    state_d = S_TERM;
                end else if (cnt_q == 16'(NXM_TIMEOUT - 1)) begin
                    // addr/wc still name the word that got no reply
                    nxm_d   = 1'b1;
                    arb_rel = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_TERM: begin
                if (!qbus.RRPLY) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                wc_d   = wc_q + 16'd1;
                addr_d = next_addr(addr_q, inh_q);
                badr_d = badr_q + 8'd1;
                if ((wc_q + 16'd1 == 16'd0) || (badr_q == 8'hFF)) begin
                    arb_rel = 1'b1;
                    state_d = S_DONE;
                end else begin
`ifdef QDMA_BURST_EN
                    if (burst_q == 3'(QSIC_BURST_LIMIT - 1)) begin
                        arb_rel = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        burst_d = burst_q + 3'd1;
                        state_d = S_ADDR;
                    end
`else
                    arb_rel = 1'b1;
                    state_d = S_REQ;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Every state measures its dwell time from entry
        if (state_d != state_q || state_q == S_IDLE) begin
            cnt_d = 16'd0;
        end
    end

    // State and datapath registers
    always_ff @(posedge qclk) begin
        if (init) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            addr_q  <= 22'd0;
            wc_q    <= 16'd0;
            badr_q  <= 8'd0;
            nxm_q   <= 1'b0;
            wdat_q  <= 16'd0;
            we_q    <= 1'b0;
            dir_q   <= 1'b0;
            inh_q   <= 1'b0;
`ifdef QDMA_BURST_EN
            burst_q <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            badr_q  <= badr_d;
            nxm_q   <= nxm_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            dir_q   <= dir_d;
            inh_q   <= inh_d;
`ifdef QDMA_BURST_EN
            burst_q <= burst_d;
`endif
        end
    end

    // Bus line decode from the current state; everything released outside a cycle
    always_comb begin
        dal_oe  = 1'b0;
        dal_val = 22'd0;
        tsync   = 1'b0;
        tdin    = 1'b0;
        tdout   = 1'b0;
        twtbt   = 1'b0;
        tbs7    = 1'b0;
        dalbe_l = 1'b1;
        daltx   = 1'b0;
        dalst   = 1'b0;
        case (state_q)
            S_ADDR: begin
                dal_oe  = 1'b1;
                dal_val = addr_q;
                daltx   = 1'b1;
                dalbe_l = 1'b0;
                dalst   = 1'b1;
                tbs7    = (addr_q[21:13] == QSIC_BS7_PAGE);
                twtbt   = dir_q;
            end
            S_SYNC, S_DATA, S_TERM: begin
                tsync = 1'b1;
                if (dir_q) begin
                    // Buffer data stays on DAL through TERM so it outlives DOUT
                    dal_oe  = 1'b1;
                    dal_val = {6'd0, buf_rdata};
                    daltx   = 1'b1;
                    dalbe_l = 1'b0;
                    tdout   = (state_q == S_DATA) && strobe_on;
                end else begin
                    tdin = (state_q != S_TERM);
                end
            end
            default: begin
            end
        endcase
    end

    assign ZDAL         = dal_oe ? dal_val : {22{1'bz}};
    assign qbus.TSYNC   = tsync;
    assign qbus.TDIN    = tdin;
    assign qbus.TDOUT   = tdout;
    assign qbus.TWTBT   = twtbt;
    assign qbus.TBS7    = tbs7;
    assign qbus.DALbe_L = dalbe_l;
    assign qbus.DALtx   = daltx;
    assign qbus.DALst   = dalst;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign nxm       = nxm_q;
    assign addr_out  = addr_q;
    assign wc_out    = wc_q;
    assign buf_addr  = badr_q;
    assign buf_wdata = wdat_q;
    assign buf_we    = we_q;

endmodule

// File: tb/tb_qdma_master.sv
// Directed bench for qdma_master: bus/arbiter/memory responder plus sector buffer model.
// Latency: n/a.
// Backpressure: responder replies a fixed 2 cycles after DIN/DOUT, or never for nxm.
module tb_qdma_master;

    logic        qclk = 1'b0;
    logic        init, start, to_mem, inh_ba;
    logic [21:0] addr_in;
    logic [15:0] wc_in;
    wire         busy, done, nxm, buf_we;
    wire  [21:0] addr_out;
    wire  [15:0] wc_out, buf_wdata;
    wire  [7:0]  buf_addr;
    logic [15:0] buf_rdata = 16'd0;
    wire  [21:0] ZDAL;
    logic [21:0] mem_dat;
    logic        mem_oe;

    logic [15:0] bufm [256];
    logic [7:0]  wl_a [512];
    logic [15:0] wl_d [512];
    int          wcnt = 0;
    int          dcnt = 0;
    int          checks = 0;
    int          failures = 0;

    qdma_master_if qbus ();

    assign ZDAL = mem_oe ? mem_dat : {22{1'bz}};

    qdma_master dut (
        .qclk(qclk), .init(init), .start(start), .to_mem(to_mem),
        .addr_in(addr_in), .wc_in(wc_in), .inh_ba(inh_ba),
        .busy(busy), .done(done), .nxm(nxm),
        .addr_out(addr_out), .wc_out(wc_out), .buf_addr(buf_addr),
        .buf_rdata(buf_rdata), .buf_wdata(buf_wdata), .buf_we(buf_we),
        .qbus(qbus), .ZDAL(ZDAL)
    );

    initial forever #5 qclk = ~qclk;

    // Sector buffer: 1-cycle read latency, writes logged for later comparison
    always @(posedge qclk) begin
        buf_rdata <= bufm[buf_addr];
        if (buf_we) begin
            wl_a[wcnt[8:0]] <= buf_addr;
            wl_d[wcnt[8:0]] <= buf_wdata;
            wcnt <= wcnt + 1;
        end
        if (done) dcnt <= dcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return qbus.TDMR;
            1: return qbus.TSACK;
            2: return qbus.DALst;
            3: return qbus.TSYNC;
            4: return qbus.TDIN | qbus.TDOUT;
            5: return ~(qbus.TDIN | qbus.TDOUT);
            6: return done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int k, input string tag);
        int n = 0;
        while (!sig(k) && n < 500) begin
            @(negedge qclk);
            n++;
        end
        check(tag, 32'(sig(k)), 32'd1);
    endtask

    task automatic kick(input logic dir, input logic inh, input logic [21:0] a, input logic [15:0] w);
        to_mem = dir; inh_ba = inh; addr_in = a; wc_in = w;
        start = 1'b1;
        @(negedge qclk);
        start = 1'b0;
    endtask

    // One word: grant the bus, watch address/data phases, optionally reply
    task automatic bus_word(input bit reply, input logic [15:0] rdat,
                            output logic [21:0] a, output logic [15:0] wd,
                            output logic bs7, output logic wtbt);
        wd = 16'd0;
        wait_sig(0, "tdmr_req");
        qbus.RDMGI = 1'b1;
        #1 check("tdmgo_absorbed", 32'(qbus.TDMGO), 32'd0);
        wait_sig(1, "tsack_on_grant");
        qbus.RDMGI = 1'b0;
        wait_sig(2, "addr_phase");
        a = ZDAL; bs7 = qbus.TBS7; wtbt = qbus.TWTBT;
        wait_sig(3, "tsync");
        wait_sig(4, "strobe");
        if (qbus.TDOUT) wd = ZDAL[15:0];
        if (reply) begin
            repeat (2) @(negedge qclk);
            mem_dat = {6'd0, rdat};
            mem_oe = ~qbus.TDOUT;
            qbus.RRPLY = 1'b1;
            wait_sig(5, "strobe_drop");
            qbus.RRPLY = 1'b0;
            mem_oe = 1'b0;
        end
    endtask

    initial begin
        logic [21:0] a;
        logic [15:0] wd;
        logic        bs7, wtbt;
        int          wb, db, n;

        for (int i = 0; i < 256; i++) bufm[i] = 16'(i + 1);
        init = 1'b1; start = 1'b0; to_mem = 1'b0; inh_ba = 1'b0;
        addr_in = 22'd0; wc_in = 16'd0; mem_dat = 22'd0; mem_oe = 1'b0;
        qbus.RDMGI = 1'b0; qbus.RSYNC = 1'b0; qbus.RRPLY = 1'b0;
        repeat (3) @(negedge qclk);

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_nxm", 32'(nxm), 0);
        check("rst_tlines", 32'({qbus.TDMR, qbus.TSACK, qbus.TSYNC, qbus.TDIN, qbus.TDOUT, qbus.TWTBT, qbus.TBS7}), 0);
        check("rst_dal", 32'({qbus.DALbe_L, qbus.DALtx, qbus.DALst}), 32'b100);
        check("rst_buf", 32'({buf_we, buf_addr}), 0);
        check("rst_addr_wc", 32'(addr_out) ^ 32'(wc_out), 0);
        init = 1'b0;
        @(negedge qclk);

        // Idle grant passes straight through, never absorbed
        qbus.RDMGI = 1'b1;
        #1 check("idle_tdmgo_hi", 32'(qbus.TDMGO), 1);
        @(negedge qclk);
        check("idle_no_sack", 32'(qbus.TSACK), 0);
        qbus.RDMGI = 1'b0;
        #1 check("idle_tdmgo_lo", 32'(qbus.TDMGO), 0);
        @(negedge qclk);

        // DATI: 4 words from 0o1000 into buffer 0..3
        wb = wcnt; db = dcnt;
        kick(1'b0, 1'b0, 22'o1000, -16'sd4);
        check("dati_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            bus_word(1'b1, 16'(16'hA000 + i), a, wd, bs7, wtbt);
            check("dati_addr", 32'(a), 32'(22'o1000 + 2 * i));
            check("dati_wtbt_bs7", 32'({wtbt, bs7}), 0);
        end
        wait_sig(6, "dati_done");
        check("dati_addr_out", 32'(addr_out), 32'(22'o1010));
        check("dati_wc_out", 32'(wc_out), 0);
        check("dati_busy_off", 32'(busy), 0);
        repeat (3) @(negedge qclk);
        check("dati_done_cnt", 32'(dcnt - db), 1);
        check("dati_we_cnt", 32'(wcnt - wb), 4);
        for (int i = 0; i < 4; i++) begin
            check("dati_buf_addr", 32'(wl_a[wb + i]), 32'(i));
            check("dati_buf_data", 32'(wl_d[wb + i]), 32'(16'hA000 + i));
        end

        // DATO with inhibited address increment, buffer holds 1,2,3
        db = dcnt;
        kick(1'b1, 1'b1, 22'o2000, -16'sd3);
        for (int i = 0; i < 3; i++) begin
            bus_word(1'b1, 16'd0, a, wd, bs7, wtbt);
            check("dato_addr", 32'(a), 32'(22'o2000));
            check("dato_data", 32'(wd), 32'(i + 1));
            check("dato_wtbt", 32'(wtbt), 1);
        end
        wait_sig(6, "dato_done");
        check("dato_addr_out", 32'(addr_out), 32'(22'o2000));
        check("dato_wc_out", 32'(wc_out), 0);
        repeat (3) @(negedge qclk);
        check("dato_done_cnt", 32'(dcnt - db), 1);

        // NXM on the second word, I/O-page address so BS7 is exercised
        db = dcnt;
        kick(1'b0, 1'b0, 22'o17760100, -16'sd3);
        bus_word(1'b1, 16'h1234, a, wd, bs7, wtbt);
        check("io_bs7", 32'(bs7), 1);
        bus_word(1'b0, 16'h0, a, wd, bs7, wtbt);
        n = 0;
        while (!done && n < 500) begin
            @(negedge qclk);
            n++;
        end
        check("nxm_cycles", 32'(n), 201);
        check("nxm_flag", 32'(nxm), 1);
        check("nxm_released", 32'({qbus.TSYNC, qbus.TDIN, qbus.TDOUT, qbus.TSACK, qbus.DALbe_L}), 32'b00001);
        check("nxm_wc_out", 32'(wc_out), 32'(16'hFFFE));
        check("nxm_addr_out", 32'(addr_out), 32'(22'o17760102));
        repeat (3) @(negedge qclk);
        check("nxm_sticky", 32'(nxm), 1);
        check("nxm_done_cnt", 32'(dcnt - db), 1);

        // Zero word count: straight to done, nxm cleared by the start
        kick(1'b0, 1'b0, 22'o1000, 16'd0);
        check("wc0_done", 32'({done, busy, qbus.TDMR}), 32'b100);
        check("wc0_nxm_clear", 32'(nxm), 0);
        @(negedge qclk);
        check("wc0_done_pulse", 32'(done), 0);

        // -300 words: stops at a full sector of 256
        db = dcnt;
        kick(1'b1, 1'b0, 22'o4000, -16'sd300);
        for (int i = 0; i < 256; i++) begin
            bus_word(1'b1, 16'd0, a, wd, bs7, wtbt);
            check("sect_data", 32'(wd), 32'(16'(i + 1)));
        end
        wait_sig(6, "sect_done");
        check("sect_wc_out", 32'(wc_out), 32'(16'hFFD4));
        check("sect_addr_out", 32'(addr_out), 32'(22'o5000));
        repeat (5) @(negedge qclk);
        check("sect_quiet", 32'({qbus.TDMR, busy}), 0);
        check("sect_done_cnt", 32'(dcnt - db), 1);

        // Reset while waiting in DATA
        db = dcnt;
        kick(1'b0, 1'b0, 22'o1000, -16'sd2);
        bus_word(1'b0, 16'h0, a, wd, bs7, wtbt);
        repeat (5) @(negedge qclk);
        check("mid_in_data", 32'(qbus.TDIN), 1);
        init = 1'b1;
        @(negedge qclk);
        check("mid_tlines", 32'({qbus.TDMR, qbus.TSACK, qbus.TSYNC, qbus.TDIN, qbus.TDOUT, qbus.TWTBT, qbus.TBS7}), 0);
        check("mid_dal", 32'({qbus.DALbe_L, qbus.DALtx, qbus.DALst}), 32'b100);
        check("mid_busy_done", 32'({busy, done}), 0);
        init = 1'b0;
        repeat (5) @(negedge qclk);
        check("mid_no_done", 32'(dcnt - db), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
